lr_stack: RTL and testbench

Return-address stack for the XM23 pipeline, the call side of the link mechanism. A branch-with-link at the execute stage pushes its return address (PC + 2). A link-back request from the return detector pops the newest entry and presents it as a registered redirect target for the fetch stage. `lr_o` always exposes the current top entry as the architectural LR value seen by the pipeline.

---
 rtl/lr_stack.sv | 125 ++++++++++++
 tb/tb_lr_stack.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lr_stack.sv
// Return-address stack for the XM23 link mechanism: BL pushes PC+2, link-back pops to a registered redirect.
// Define LR_STACK_OVERWRITE_EN to make a push while full overwrite the oldest entry instead of being dropped.
module lr_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stall_i,
    input  logic                     call_i,
    input  logic [PC_W-1:0]          pc_i,
    input  logic                     link_back_i,
    output logic [PC_W-1:0]          lr_o,
    output logic                     ret_valid_o,
    output logic [PC_W-1:0]          ret_addr_o,
    output logic [$clog2(DEPTH):0]   depth_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wp_q, wp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ret_valid_q, ret_valid_d;
    logic [PC_W-1:0] ret_addr_q, ret_addr_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [AW-1:0]   top_idx;
    logic [PC_W-1:0] push_data;
    logic            empty, full;

    assign top_idx   = wp_q - AW'(1);
    assign push_data = pc_i + PC_W'(2);
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));

    always_comb begin
        wp_d        = wp_q;
        cnt_d       = cnt_q;
        ret_valid_d = 1'b0;
        ret_addr_d  = ret_addr_q;
        ovf_d       = ovf_q;
        udf_d       = udf_q;
        mem_we      = 1'b0;
        mem_waddr   = wp_q;

        if (!stall_i) begin
            if (call_i && link_back_i) begin
                if (!empty) begin
                    // Return then call: hand out the old top and replace it in place.
                    ret_valid_d = 1'b1;
                    ret_addr_d  = mem_q[top_idx];
                    mem_we      = 1'b1;
                    mem_waddr   = top_idx;
                end else begin
                    udf_d  = 1'b1;
                    mem_we = 1'b1;
                    wp_d   = wp_q + AW'(1);
                    cnt_d  = cnt_q + CW'(1);
                end
            end else if (call_i) begin
                if (full) begin
                    ovf_d = 1'b1;
`ifdef LR_STACK_OVERWRITE_EN
                    mem_we = 1'b1;
                    wp_d   = wp_q + AW'(1);
`else
                    mem_we = 1'b0;
`endif
                end else begin
                    mem_we = 1'b1;
                    wp_d   = wp_q + AW'(1);
                    cnt_d  = cnt_q + CW'(1);
                end
            end else if (link_back_i) begin
                if (empty) begin
                    udf_d = 1'b1;
                end else begin
                    ret_valid_d = 1'b1;
                    ret_addr_d  = mem_q[top_idx];
                    wp_d        = top_idx;
                    cnt_d       = cnt_q - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q        <= '0;
            cnt_q       <= '0;
            ret_valid_q <= 1'b0;
            ret_addr_q  <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            if (mem_we) begin
                mem_q[mem_waddr] <= push_data;
            end
            wp_q        <= wp_d;
            cnt_q       <= cnt_d;
            ret_valid_q <= ret_valid_d;
            ret_addr_q  <= ret_addr_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign lr_o        = empty ? '0 : mem_q[top_idx];
    assign ret_valid_o = ret_valid_q;
    assign ret_addr_o  = ret_addr_q;
    assign depth_o     = cnt_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

endmodule

// File: tb/tb_lr_stack.sv
// Directed bench for lr_stack (DEPTH=4, PC_W=16); full-push expectations follow LR_STACK_OVERWRITE_EN.
module tb_lr_stack;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        call_i;
    logic [15:0] pc_i;
    logic        link_back_i;
    logic [15:0] lr_o;
    logic        ret_valid_o;
    logic [15:0] ret_addr_o;
    logic [2:0]  depth_o;
    logic        overflow_o;
    logic        underflow_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [15:0] exp_pop [4];
    logic [15:0] exp_full_lr;

    lr_stack #(.DEPTH(4), .PC_W(16)) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .call_i      (call_i),
        .pc_i        (pc_i),
        .link_back_i (link_back_i),
        .lr_o        (lr_o),
        .ret_valid_o (ret_valid_o),
        .ret_addr_o  (ret_addr_o),
        .depth_o     (depth_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [15:0] pc);
        call_i = 1'b1;
        pc_i   = pc;
        tick();
        call_i = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_lr"},    32'(lr_o),        32'h0);
        chk({tag, "_rv"},    32'(ret_valid_o), 32'h0);
        chk({tag, "_ra"},    32'(ret_addr_o),  32'h0);
        chk({tag, "_depth"}, 32'(depth_o),     32'h0);
        chk({tag, "_ovf"},   32'(overflow_o),  32'h0);
        chk({tag, "_udf"},   32'(underflow_o), 32'h0);
    endtask

    initial begin
`ifdef LR_STACK_OVERWRITE_EN
        exp_pop[0] = 16'h5002; exp_pop[1] = 16'h4002;
        exp_pop[2] = 16'h3002; exp_pop[3] = 16'h2002;
        exp_full_lr = 16'h5002;
`else
        exp_pop[0] = 16'h4002; exp_pop[1] = 16'h3002;
        exp_pop[2] = 16'h2002; exp_pop[3] = 16'h1002;
        exp_full_lr = 16'h4002;
`endif
        rst_i = 1'b1; stall_i = 1'b0; call_i = 1'b0; pc_i = '0; link_back_i = 1'b0;
        tick();
        tick();
        chk_reset_state("reset");
        rst_i = 1'b0;
        tick();

        // Single push / pop round trip
        push(16'h0100);
        chk("push1_lr",    32'(lr_o),    32'h0102);
        chk("push1_depth", 32'(depth_o), 32'd1);
        link_back_i = 1'b1;
        tick();
        link_back_i = 1'b0;
        chk("pop1_rv",    32'(ret_valid_o), 32'h1);
        chk("pop1_ra",    32'(ret_addr_o),  32'h0102);
        chk("pop1_depth", 32'(depth_o),     32'd0);
        chk("pop1_lr",    32'(lr_o),        32'h0);
        tick();
        chk("idle_rv", 32'(ret_valid_o), 32'h0);
        chk("idle_ra", 32'(ret_addr_o),  32'h0102);

        // Back-to-back pops
        push(16'h0010);
        push(16'h0020);
        push(16'h0030);
        chk("b2b_depth3", 32'(depth_o), 32'd3);
        link_back_i = 1'b1;
        tick();
        chk("b2b_rv0", 32'(ret_valid_o), 32'h1);
        chk("b2b_ra0", 32'(ret_addr_o),  32'h0032);
        tick();
        chk("b2b_rv1", 32'(ret_valid_o), 32'h1);
        chk("b2b_ra1", 32'(ret_addr_o),  32'h0022);
        tick();
        link_back_i = 1'b0;
        chk("b2b_rv2", 32'(ret_valid_o), 32'h1);
        chk("b2b_ra2", 32'(ret_addr_o),  32'h0012);
        chk("b2b_depth0", 32'(depth_o), 32'd0);
        tick();
        chk("b2b_idle_rv", 32'(ret_valid_o), 32'h0);

        // Underflow and PC wrap
        link_back_i = 1'b1;
        tick();
        link_back_i = 1'b0;
        chk("udf_rv",  32'(ret_valid_o), 32'h0);
        chk("udf_ra",  32'(ret_addr_o),  32'h0012);
        chk("udf_flag", 32'(underflow_o), 32'h1);
        tick();
        chk("udf_sticky", 32'(underflow_o), 32'h1);
        push(16'hFFFE);
        chk("wrap_lr",    32'(lr_o),    32'h0000);
        chk("wrap_depth", 32'(depth_o), 32'd1);
        link_back_i = 1'b1;
        tick();
        link_back_i = 1'b0;
        chk("wrap_pop_rv", 32'(ret_valid_o), 32'h1);
        chk("wrap_pop_ra", 32'(ret_addr_o),  32'h0000);

        // Full stack behaviour
        push(16'h1000);
        push(16'h2000);
        push(16'h3000);
        push(16'h4000);
        chk("full_depth", 32'(depth_o),    32'd4);
        chk("full_ovf0",  32'(overflow_o), 32'h0);
        push(16'h5000);
        chk("full_ovf1",   32'(overflow_o), 32'h1);
        chk("full_depth2", 32'(depth_o),    32'd4);
        chk("full_lr",     32'(lr_o),       32'(exp_full_lr));
        link_back_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) link_back_i = 1'b0;
            chk($sformatf("full_pop%0d_rv", i), 32'(ret_valid_o), 32'h1);
            chk($sformatf("full_pop%0d_ra", i), 32'(ret_addr_o),  32'(exp_pop[i]));
        end
        chk("full_empty", 32'(depth_o),    32'd0);
        chk("ovf_sticky", 32'(overflow_o), 32'h1);

        // Simultaneous call and link-back, then the same stalled
        push(16'h0A00);
        chk("sim_pre_lr", 32'(lr_o), 32'h0A02);
        call_i = 1'b1; pc_i = 16'h0B00; link_back_i = 1'b1;
        tick();
        call_i = 1'b0; link_back_i = 1'b0;
        chk("sim_rv",    32'(ret_valid_o), 32'h1);
        chk("sim_ra",    32'(ret_addr_o),  32'h0A02);
        chk("sim_lr",    32'(lr_o),        32'h0B02);
        chk("sim_depth", 32'(depth_o),     32'd1);
        stall_i = 1'b1; call_i = 1'b1; pc_i = 16'h0C00; link_back_i = 1'b1;
        tick();
        stall_i = 1'b0; call_i = 1'b0; link_back_i = 1'b0;
        chk("stall_rv",    32'(ret_valid_o), 32'h0);
        chk("stall_ra",    32'(ret_addr_o),  32'h0A02);
        chk("stall_lr",    32'(lr_o),        32'h0B02);
        chk("stall_depth", 32'(depth_o),     32'd1);

        // Async reset during a pop pulse
        push(16'h0200);
        push(16'h0300);
        link_back_i = 1'b1;
        tick();
        link_back_i = 1'b0;
        chk("prerst_rv", 32'(ret_valid_o), 32'h1);
        chk("prerst_ra", 32'(ret_addr_o),  32'h0302);
        #2;
        rst_i = 1'b1;
        #1;
        chk_reset_state("asyncrst");
        #2;
        rst_i = 1'b0;
        tick();
        chk_reset_state("postrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
